cop_req_issue: RTL

- Consumes the 45-bit COP instruction-fetch request entries queued in the COP command FIFO and turns each entry into a sequence of fixed-size read bursts toward the DDR command arbiter.
- Each request has a fixed fetch length and is split into BURSTS_PER_REQ bursts at consecutive addresses.
- Each burst carries the requester position/source tag so the read-data router can return data to the right COP.
- A credit counter limits outstanding bursts.

---
 rtl/cop_req_issue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cop_req_issue.sv
// Turns COP command-FIFO fetch entries into a train of fixed-size DDR read bursts,
// tagged with the requester position/source, under an outstanding-burst credit limit.
module cop_req_issue #(
    parameter int unsigned BURSTS_PER_REQ  = 16,
    parameter int unsigned BURST_BEATS     = 64,
    parameter int unsigned ADDR_STEP       = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fifo_rd_en,
    input  logic [44:0] fifo_dout,
    input  logic        fifo_valid,
    input  logic        fifo_empty,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [29:0] cmd_addr,
    output logic [7:0]  cmd_len,
    output logic [7:0]  cmd_pos_1st,
    output logic [2:0]  cmd_pos_2nd,
    output logic [1:0]  cmd_src_type,
    output logic        cmd_last,
    input  logic        burst_done,
    output logic        busy,
    output logic        err_wr
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPop     = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StIssue   = 2'd3;

    localparam logic [7:0]  LastK  = 8'(BURSTS_PER_REQ - 1);
    localparam logic [7:0]  LenVal = 8'(BURST_BEATS - 1);
    localparam logic [29:0] Step   = 30'(ADDR_STEP);
    localparam logic [3:0]  MaxOut = 4'(MAX_OUTSTANDING);

    logic [1:0]  state_q, state_d;
    logic [7:0]  k_q, k_d;
    logic [3:0]  out_q, out_d;
    logic [29:0] addr_q, addr_d;
    logic [7:0]  pos1_q, pos1_d;
    logic [2:0]  pos2_q, pos2_d;
    logic [1:0]  src_q, src_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        rd_q, rd_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [7:0]  len_q;
    logic        hs;
    logic        dec;

    assign hs  = valid_q & cmd_ready;
    // A completion with nothing outstanding is ignored.
    assign dec = burst_done & (out_q != 4'd0);

    always_comb begin
        out_d = out_q;
        if (hs && !dec) begin
            out_d = out_q + 4'd1;
        end else if (!hs && dec) begin
            out_d = out_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        src_d   = src_q;
        valid_d = valid_q;
        last_d  = last_q;
        rd_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = StPop;
                end
            end
            StPop: state_d = StCapture;
            StCapture: begin
                if (fifo_valid) begin
                    if (!fifo_dout[0]) begin
                        state_d = StIdle;
                    end else if (fifo_dout[1]) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        addr_d  = fifo_dout[44:15];
                        pos1_d  = fifo_dout[9:2];
                        pos2_d  = fifo_dout[12:10];
                        src_d   = fifo_dout[14:13];
                        k_d     = 8'd0;
                        last_d  = (LastK == 8'd0);
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (hs) begin
                    // Drop valid for one cycle while the next address registers.
                    valid_d = 1'b0;
                    k_d     = k_q + 8'd1;
                    addr_d  = addr_q + Step;
                    last_d  = ((k_q + 8'd1) == LastK);
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = StIdle;
                    end
                end else if (!valid_q) begin
                    valid_d = (out_d < MaxOut);
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle) | (out_d != 4'd0) | rd_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= 8'd0;
            out_q   <= 4'd0;
            addr_q  <= 30'd0;
            pos1_q  <= 8'd0;
            pos2_q  <= 3'd0;
            src_q   <= 2'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            len_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            pos1_q  <= pos1_d;
            pos2_q  <= pos2_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            len_q   <= LenVal;
        end
    end

    assign fifo_rd_en   = rd_q;
    assign cmd_valid    = valid_q;
    assign cmd_addr     = addr_q;
    assign cmd_len      = len_q;
    assign cmd_pos_1st  = pos1_q;
    assign cmd_pos_2nd  = pos2_q;
    assign cmd_src_type = src_q;
    assign cmd_last     = last_q;
    assign busy         = busy_q;
    assign err_wr       = err_q;

endmodule
